// File: rtl/vu_envelope_follower.sv
// vu_envelope_follower: per-channel attack/hold/release peak envelope feeding the VU PWM driver.
// Latency: data_en -> level_en is 2 clk; one sample per channel accepted every cycle.
// Backpressure: none; audio_enable=0 drops in-flight samples and clears state.
// Optional clip stretch indicator: define VU_CLIP_DETECT_EN (l_clip/r_clip tie to 0 otherwise).

// vu_env_channel: one channel's rectifier + envelope ballistics.
// Latency: 2 clk (stage 1 rectify, stage 2 envelope/level register).
// Backpressure: none; a strobe every cycle is processed.
module vu_env_channel #(
  parameter int DATA_W        = 24,
  parameter int OUT_W         = 8,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 8,
  parameter int HOLD_SAMPLES  = 4800
`ifdef VU_CLIP_DETECT_EN
  ,parameter int CLIP_STRETCH = 9600
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              audio_enable,
  input  logic              data_en,
  input  logic [DATA_W-1:0] sample,
  output logic [OUT_W-1:0]  level,
  output logic              level_en,
  output logic              clip
);

  localparam int MAG_W = DATA_W - 1;
  localparam logic [MAG_W-1:0]  MAG_MAX   = {MAG_W{1'b1}};
  localparam logic [MAG_W-1:0]  MAG_ONE   = MAG_W'(1);
  localparam logic [DATA_W-1:0] NEG_FS    = {1'b1, {MAG_W{1'b0}}};
  localparam logic [15:0]       HOLD_LOAD = 16'(HOLD_SAMPLES);

  typedef enum logic [1:0] {ST_ATTACK, ST_HOLD, ST_RELEASE, ST_IDLE} env_state_t;

  logic [MAG_W-1:0] mag_c;
  logic             s1_vld;
  logic [MAG_W-1:0] s1_mag;
  logic [MAG_W-1:0] env, env_n;
  logic [15:0]      hold_cnt, hold_n;
  logic [MAG_W-1:0] diff_up, diff_dn, step_up, step_dn;
  env_state_t       state;

  // Rectify: negative full scale has no positive twin, so it saturates.
  always_comb begin
    mag_c = sample[MAG_W-1:0];
    if (sample == NEG_FS) begin
      mag_c = MAG_MAX;
    end else if (sample[DATA_W-1]) begin
      mag_c = MAG_W'(~sample + DATA_W'(1));
    end
  end

  // Stage 1: register magnitude and its valid; disable kills the slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s1_mag <= '0;
    end else if (!audio_enable) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= data_en;
      if (data_en) s1_mag <= mag_c;
    end
  end

  // Ballistics decision and step sizes; min step 1 guarantees convergence to mag.
  always_comb begin
    diff_up = s1_mag - env;
    diff_dn = env - s1_mag;
    step_up = diff_up >> ATTACK_SHIFT;
    step_dn = diff_dn >> RELEASE_SHIFT;
    if (step_up == '0) step_up = MAG_ONE;
    if (step_dn == '0) step_dn = MAG_ONE;
    if (s1_mag > env)           state = ST_ATTACK;
    else if (hold_cnt != '0)    state = ST_HOLD;
    else if (env > s1_mag)      state = ST_RELEASE;
    else                        state = ST_IDLE;
  end

  // Next envelope/hold; steps never exceed the distance to mag, so no wrap.
  always_comb begin
    env_n  = env;
    hold_n = hold_cnt;
    case (state)
      ST_ATTACK: begin
        env_n  = env + step_up;
        hold_n = HOLD_LOAD;
      end
      ST_HOLD:    hold_n = hold_cnt - 16'd1;
      ST_RELEASE: env_n  = env - step_dn;
      default: ;
    endcase
  end

  // Stage 2: commit envelope, publish level with a one-cycle strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      env      <= '0;
      hold_cnt <= '0;
      level    <= '0;
      level_en <= 1'b0;
    end else if (!audio_enable) begin
      env      <= '0;
      hold_cnt <= '0;
      level    <= '0;
      level_en <= 1'b0;
    end else begin
      level_en <= s1_vld;
      if (s1_vld) begin
        env      <= env_n;
        hold_cnt <= hold_n;
        level    <= env_n[MAG_W-1 -: OUT_W];
      end
    end
  end

`ifdef VU_CLIP_DETECT_EN
  localparam logic [15:0] CLIP_LOAD = 16'(CLIP_STRETCH);
  logic [15:0] clip_cnt, clip_cnt_n;

  // Full-scale hit reloads the stretch window; every other strobe ages it.
  always_comb begin
    clip_cnt_n = clip_cnt;
    if (s1_mag == MAG_MAX)     clip_cnt_n = CLIP_LOAD;
    else if (clip_cnt != '0)   clip_cnt_n = clip_cnt - 16'd1;
  end

  // Clip flag is registered alongside level so both change on the same strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clip_cnt <= '0;
      clip     <= 1'b0;
    end else if (!audio_enable) begin
      clip_cnt <= '0;
      clip     <= 1'b0;
    end else if (s1_vld) begin
      clip_cnt <= clip_cnt_n;
      clip     <= (clip_cnt_n != '0);
    end
  end
`else
  assign clip = 1'b0;
`endif

endmodule

module vu_envelope_follower #(
  parameter int DATA_W        = 24,
  parameter int OUT_W         = 8,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 8,
  parameter int HOLD_SAMPLES  = 4800
`ifdef VU_CLIP_DETECT_EN
  ,parameter int CLIP_STRETCH = 9600
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              audio_enable,
  input  logic              l_data_en,
  input  logic              r_data_en,
  input  logic [DATA_W-1:0] l_sample,
  input  logic [DATA_W-1:0] r_sample,
  output logic [OUT_W-1:0]  l_level,
  output logic [OUT_W-1:0]  r_level,
  output logic              l_level_en,
  output logic              r_level_en,
  output logic              l_clip,
  output logic              r_clip
);

  vu_env_channel #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .ATTACK_SHIFT(ATTACK_SHIFT),
    .RELEASE_SHIFT(RELEASE_SHIFT), .HOLD_SAMPLES(HOLD_SAMPLES)
`ifdef VU_CLIP_DETECT_EN
    ,.CLIP_STRETCH(CLIP_STRETCH)
`endif
  ) u_left (
    .clk(clk), .reset_n(reset_n), .audio_enable(audio_enable),
    .data_en(l_data_en), .sample(l_sample),
    .level(l_level), .level_en(l_level_en), .clip(l_clip)
  );

  vu_env_channel #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .ATTACK_SHIFT(ATTACK_SHIFT),
    .RELEASE_SHIFT(RELEASE_SHIFT), .HOLD_SAMPLES(HOLD_SAMPLES)
`ifdef VU_CLIP_DETECT_EN
    ,.CLIP_STRETCH(CLIP_STRETCH)
`endif
  ) u_right (
    .clk(clk), .reset_n(reset_n), .audio_enable(audio_enable),
    .data_en(r_data_en), .sample(r_sample),
    .level(r_level), .level_en(r_level_en), .clip(r_clip)
  );

endmodule

// File: tb/tb_vu_envelope_follower.sv
// tb_vu_envelope_follower: scoreboard bench for vu_envelope_follower.
// Expected level/clip per strobe are computed when the sample is driven and popped on level_en.
// Clip expectations follow VU_CLIP_DETECT_EN as compiled.
module tb_vu_envelope_follower;

`ifdef VU_CLIP_DETECT_EN
  localparam int CLIP_ON = 1;
`else
  localparam int CLIP_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        audio_enable = 1'b0;
  logic        l_data_en = 1'b0, r_data_en = 1'b0;
  logic [23:0] l_sample = '0, r_sample = '0;
  logic [7:0]  l_level, r_level;
  logic        l_level_en, r_level_en, l_clip, r_clip;

  vu_envelope_follower dut (
    .clk(clk), .reset_n(reset_n), .audio_enable(audio_enable),
    .l_data_en(l_data_en), .r_data_en(r_data_en),
    .l_sample(l_sample), .r_sample(r_sample),
    .l_level(l_level), .r_level(r_level),
    .l_level_en(l_level_en), .r_level_en(r_level_en),
    .l_clip(l_clip), .r_clip(r_clip)
  );

  always #5 clk = ~clk;

  typedef struct {
    int level;
    int clip;
    int cyc;
  } exp_t;

  exp_t ql[$];
  exp_t qr[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   m_env[2];
  int   m_hold[2];
  int   m_clip[2];
  int   last_l = 0, last_r = 0, last_lclip = 0, prev_l = 0;
  bit   decay_l = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h at cyc %0d", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_env[c] = 0; m_hold[c] = 0; m_clip[c] = 0;
    end
  endtask

  // Reference ballistics written from the behavioural description, in plain integer math.
  function automatic exp_t model(input int ch, input logic [23:0] s);
    exp_t e;
    int mag, env, step;
    mag = s[23] ? (32'h1000000 - int'(s)) : int'(s);
    if (mag > 'h7FFFFF) mag = 'h7FFFFF;
    env = m_env[ch];
    if (mag > env) begin
      step = (mag - env) / 4;
      if (step < 1) step = 1;
      env = env + step;
      m_hold[ch] = 4800;
    end else if (m_hold[ch] != 0) begin
      m_hold[ch] = m_hold[ch] - 1;
    end else if (env > mag) begin
      step = (env - mag) / 256;
      if (step < 1) step = 1;
      env = env - step;
    end
    if (mag == 'h7FFFFF) m_clip[ch] = 9600;
    else if (m_clip[ch] > 0) m_clip[ch] = m_clip[ch] - 1;
    m_env[ch] = env;
    e.level = env / 32768;
    e.clip  = (CLIP_ON != 0 && m_clip[ch] != 0) ? 1 : 0;
    e.cyc   = cyc;
    return e;
  endfunction

  // Drive one cycle of strobes (called at negedge); track=0 means the sample is expected to be dropped.
  task automatic send(input bit le, input logic [23:0] ls, input bit re, input logic [23:0] rs,
                      input bit track = 1'b1);
    l_data_en = le; l_sample = ls;
    r_data_en = re; r_sample = rs;
    if (track && le) ql.push_back(model(0, ls));
    if (track && re) qr.push_back(model(1, rs));
    @(negedge clk);
    l_data_en = 1'b0;
    r_data_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Output monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (l_level_en) begin
      if (ql.size() == 0) chk("l_spurious_strobe", 1, 0);
      else begin
        e = ql.pop_front();
        chk("l_level", int'(l_level), e.level);
        chk("l_clip", int'(l_clip), e.clip);
        chk("l_latency", cyc - e.cyc, 2);
      end
      if (decay_l) chk("l_monotonic", int'(l_level) <= prev_l, 1);
      prev_l = int'(l_level);
      last_l = int'(l_level);
      last_lclip = int'(l_clip);
    end
    if (r_level_en) begin
      if (qr.size() == 0) chk("r_spurious_strobe", 1, 0);
      else begin
        e = qr.pop_front();
        chk("r_level", int'(r_level), e.level);
        chk("r_clip", int'(r_clip), e.clip);
        chk("r_latency", cyc - e.cyc, 2);
      end
      last_r = int'(r_level);
    end
  end

  initial begin
    model_reset();
    // Reset state
    idle(3);
    chk("rst_l_level", int'(l_level), 0);
    chk("rst_r_level", int'(r_level), 0);
    chk("rst_l_en", int'(l_level_en), 0);
    chk("rst_r_en", int'(r_level_en), 0);
    chk("rst_l_clip", int'(l_clip), 0);
    chk("rst_r_clip", int'(r_clip), 0);
    reset_n = 1'b1;
    audio_enable = 1'b1;
    idle(1);

    // Reset asserted mid-stream: outputs drop at once, in-flight sample vanishes
    send(1, 24'h400000, 1, 24'h100000);
    send(1, 24'h400000, 1, 24'h200000);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_l_level", int'(l_level), 0);
    chk("midrst_r_level", int'(r_level), 0);
    chk("midrst_l_en", int'(l_level_en), 0);
    chk("midrst_r_en", int'(r_level_en), 0);
    ql.delete();
    qr.delete();
    model_reset();
    idle(2);
    reset_n = 1'b1;
    idle(1);

    // Attack step from env=0
    send(1, 24'h400000, 0, 24'h0); idle(3);
    chk("attack1", last_l, 'h20);
    send(1, 24'h400000, 0, 24'h0); idle(3);
    chk("attack2", last_l, 'h38);
    send(1, 24'h400000, 0, 24'h0); idle(3);
    chk("attack3", last_l, 'h4A);
    chk("attack_r_idle", int'(r_level), 0);

    // Converge to 0x400000, then hold and release
    for (int i = 0; i < 300 && m_env[0] != 'h400000; i++) send(1, 24'h400000, 0, 24'h0);
    idle(3);
    chk("converged", last_l, 'h80);
    repeat (4800) send(1, 24'h0, 0, 24'h0);
    idle(3);
    chk("hold_end", last_l, 'h80);
    send(1, 24'h0, 0, 24'h0); idle(3);
    chk("release_first", last_l, 'h7F);
    decay_l = 1'b1;
    for (int i = 0; i < 6000 && m_env[0] != 0; i++) send(1, 24'h0, 0, 24'h0);
    idle(3);
    decay_l = 1'b0;
    chk("decay_zero", last_l, 0);

    // Small-value arithmetic (min step 1) and negative full scale saturation
    send(1, 24'h000002, 0, 24'h0);
    send(1, 24'h000002, 0, 24'h0);
    send(1, 24'h000003, 0, 24'h0);
    send(1, 24'hFFFFFD, 0, 24'h0);
    for (int i = 0; i < 300 && m_env[0] != 'h7FFFFF; i++) send(1, 24'h800000, 0, 24'h0);
    idle(3);
    chk("negfs_level", last_l, 'hFF);
    chk("clip_set", last_lclip, CLIP_ON);
    repeat (9599) send(1, 24'h0, 0, 24'h0);
    idle(3);
    chk("clip_last_strobe", last_lclip, CLIP_ON);
    send(1, 24'h0, 0, 24'h0); idle(3);
    chk("clip_cleared", last_lclip, 0);

    // Concurrency: simultaneous and back-to-back strobes, independent levels
    send(1, 24'h7FFFFF, 1, 24'h100000);
    send(1, 24'h300000, 1, 24'hC00000);
    send(0, 24'h0, 1, 24'h800000);
    send(1, 24'h012345, 0, 24'h0);
    repeat (60) send(1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 1)), 24'($urandom));
    idle(3);

    // audio_enable low for one cycle while a sample is in flight
    send(1, 24'h400000, 1, 24'h400000, 1'b0);
    audio_enable = 1'b0;
    send(1, 24'h400000, 1, 24'h400000, 1'b0);
    audio_enable = 1'b1;
    model_reset();
    idle(3);
    chk("disable_l_level", int'(l_level), 0);
    chk("disable_r_level", int'(r_level), 0);
    chk("disable_l_clip", int'(l_clip), 0);
    send(1, 24'h400000, 1, 24'h200000); idle(3);
    chk("reenable_l", last_l, 'h20);
    chk("reenable_r", last_r, 'h10);

    idle(5);
    chk("l_queue_drained", ql.size(), 0);
    chk("r_queue_drained", qr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
